adc_channel_sequencer: RTL and testbench

Time-multiplexes the single 10-bit delta-sigma ADC across up to four analog sources through an external analog mux. Drives the mux select and discards post-switch settling frames. Captures one clean frame per channel in round-robin order and presents each result with its channel tag on a valid/ready interface to downstream audio/telemetry logic. Sits between the ADC (frame strobe ~48.8 kHz at 50 MHz) and its consumers.

---
 rtl/adc_seq_pkg.sv | 14 +
 rtl/adc_rr_pick.sv | 37 +++
 rtl/adc_channel_sequencer.sv | 140 ++++++++++++++
 tb/tb_adc_channel_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and widths for the ADC channel sequencer: FSM state encoding,
// channel index width and settle-frame discard counter width.
package adc_seq_pkg;

    localparam int CH_W  = 2;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/adc_rr_pick.sv
// Combinational round-robin search: next enabled channel strictly after i_cur,
// ascending with wrap at P_NCH-1. o_none flags an all-zero mask.
module adc_rr_pick
    import adc_seq_pkg::*;
#(
    parameter int P_NCH = 4
) (
    input  logic [CH_W-1:0]  i_cur,
    input  logic [P_NCH-1:0] i_mask,
    output logic [CH_W-1:0]  o_next,
    output logic             o_none
);

    logic [CH_W-1:0]  cand [P_NCH];
    logic [P_NCH-1:0] hit;

    // cand[gi] is the channel gi+1 steps after i_cur, modulo P_NCH.
    for (genvar gi = 0; gi < P_NCH; gi++) begin : g_cand
        logic [CH_W:0] sum;
        assign sum       = {1'b0, i_cur} + (CH_W+1)'(gi + 1);
        assign cand[gi]  = (sum >= (CH_W+1)'(P_NCH)) ? CH_W'(sum - (CH_W+1)'(P_NCH))
                                                     : sum[CH_W-1:0];
        assign hit[gi]   = i_mask[cand[gi]];
    end

    always_comb begin
        o_next = i_cur;
        o_none = 1'b1;
        for (int k = P_NCH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                o_next = cand[k];
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Round-robin ADC mux sequencer: selects a channel, discards settling frames,
// captures one frame per channel and offers it on a one-entry valid/ready register.
module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter int P_NCH     = 4,
    parameter int P_DISCARD = 1,
    parameter int P_DW      = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic [P_NCH-1:0] i_ch_en,
    input  logic [P_DW-1:0]  i_adc_dt,
    input  logic             i_adc_dt_en,
    output logic [CH_W-1:0]  o_mux_sel,
    output logic [P_DW-1:0]  o_smp_dt,
    output logic [CH_W-1:0]  o_smp_ch,
    output logic             o_smp_valid,
    input  logic             i_smp_ready,
    output logic             o_ovf,
    input  logic             i_ovf_clr,
    output logic             o_busy
);

    localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(P_NCH - 1);
    localparam logic [CNT_W-1:0] DISCARD_INIT = CNT_W'(P_DISCARD);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  mux_sel_q, mux_sel_d;
    logic [P_DW-1:0]  smp_dt_q, smp_dt_d;
    logic [CH_W-1:0]  smp_ch_q, smp_ch_d;
    logic             smp_valid_q, smp_valid_d;
    logic             ovf_q, ovf_d;

    logic [CH_W-1:0]  pick_cur;
    logic [CH_W-1:0]  pick_next;
    logic             pick_none;
    logic             capture;
    logic             overflow;

    adc_rr_pick #(
        .P_NCH (P_NCH)
    ) u_pick (
        .i_cur  (pick_cur),
        .i_mask (i_ch_en),
        .o_next (pick_next),
        .o_none (pick_none)
    );

    // Searching "after the last channel" from IDLE yields the lowest enabled one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mux_sel_d = mux_sel_q;
        pick_cur  = LAST_CH;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_run && !pick_none) begin
                    mux_sel_d = pick_next;
                    cnt_d     = DISCARD_INIT;
                    if (P_DISCARD == 0) state_d = ST_CAPTURE;
                    else                state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!i_run) begin
                    state_d = ST_IDLE;
                end else if (i_adc_dt_en) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                pick_cur = mux_sel_q;
                if (!i_run) begin
                    state_d = ST_IDLE;
                end else if (i_adc_dt_en) begin
                    capture = 1'b1;
                    if (pick_none) begin
                        state_d = ST_IDLE;
                    end else begin
                        mux_sel_d = pick_next;
                        cnt_d     = DISCARD_INIT;
                        if (P_DISCARD == 0) state_d = ST_CAPTURE;
                        else                state_d = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A capture into an occupied, unacknowledged register is dropped and flagged.
    assign overflow = capture && smp_valid_q && !i_smp_ready;

    always_comb begin
        smp_dt_d    = smp_dt_q;
        smp_ch_d    = smp_ch_q;
        smp_valid_d = smp_valid_q;
        if (capture && !overflow) begin
            smp_dt_d    = i_adc_dt;
            smp_ch_d    = mux_sel_q;
            smp_valid_d = 1'b1;
        end else if (smp_valid_q && i_smp_ready) begin
            smp_valid_d = 1'b0;
        end
        ovf_d = overflow || (ovf_q && !i_ovf_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mux_sel_q   <= '0;
            smp_dt_q    <= '0;
            smp_ch_q    <= '0;
            smp_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mux_sel_q   <= mux_sel_d;
            smp_dt_q    <= smp_dt_d;
            smp_ch_q    <= smp_ch_d;
            smp_valid_q <= smp_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_mux_sel   = mux_sel_q;
    assign o_smp_dt    = smp_dt_q;
    assign o_smp_ch    = smp_ch_q;
    assign o_smp_valid = smp_valid_q;
    assign o_ovf       = ovf_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Bench for adc_channel_sequencer: table-driven round-robin checks, hand-written
// corner sequences and randomized traffic against a frame-level reference model.
module tb_adc_channel_sequencer;

    localparam int NCH  = 4;
    localparam int DISC = 1;
    localparam int DW   = 10;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b1;
    logic           run     = 1'b0;
    logic [NCH-1:0] ch_en   = '0;
    logic [DW-1:0]  adc_dt  = '0;
    logic           adc_en  = 1'b0;
    logic           ready   = 1'b0;
    logic           ovf_clr = 1'b0;

    logic [1:0]     mux_sel;
    logic [DW-1:0]  smp_dt;
    logic [1:0]     smp_ch;
    logic           smp_valid;
    logic           ovf;
    logic           busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: which channel is live, how many frames remain to skip,
    // and the contents of the one-entry output register.
    bit m_active;
    int m_ch;
    int m_skip;
    bit m_valid;
    int m_dt;
    int m_sch;
    bit m_ovf;

    always #5 clk = ~clk;

    adc_channel_sequencer #(
        .P_NCH     (NCH),
        .P_DISCARD (DISC),
        .P_DW      (DW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_run       (run),
        .i_ch_en     (ch_en),
        .i_adc_dt    (adc_dt),
        .i_adc_dt_en (adc_en),
        .o_mux_sel   (mux_sel),
        .o_smp_dt    (smp_dt),
        .o_smp_ch    (smp_ch),
        .o_smp_valid (smp_valid),
        .i_smp_ready (ready),
        .o_ovf       (ovf),
        .i_ovf_clr   (ovf_clr),
        .o_busy      (busy)
    );

    function automatic int next_after(int cur, logic [NCH-1:0] mask);
        int n;
        for (int k = 1; k <= NCH; k++) begin
            n = (cur + k) % NCH;
            if (mask[n]) return n;
        end
        return -1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_ch = 0; m_skip = 0;
        m_valid = 0; m_dt = 0; m_sch = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        bit cap;
        bit ovf_set;
        int cap_ch;
        int nxt;
        cap = 0; cap_ch = 0;
        if (!run) begin
            m_active = 0;
        end else if (!m_active) begin
            if (ch_en != 0) begin
                m_active = 1;
                m_ch     = next_after(NCH - 1, ch_en);
                m_skip   = DISC;
            end
        end else if (adc_en) begin
            if (m_skip > 0) begin
                m_skip--;
            end else begin
                cap    = 1;
                cap_ch = m_ch;
                nxt    = next_after(m_ch, ch_en);
                if (nxt < 0) m_active = 0;
                else begin
                    m_ch   = nxt;
                    m_skip = DISC;
                end
            end
        end
        ovf_set = cap && m_valid && !ready;
        if (cap && !ovf_set) begin
            m_dt = int'(adc_dt); m_sch = cap_ch; m_valid = 1;
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
        if (ovf_set)      m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
    endtask

    task automatic compare_all(string tag);
        check({tag, "/mux_sel"}, 32'(mux_sel), 32'(m_ch));
        check({tag, "/smp_dt"}, 32'(smp_dt), 32'(m_dt));
        check({tag, "/smp_ch"}, 32'(smp_ch), 32'(m_sch));
        check({tag, "/smp_valid"}, 32'(smp_valid), 32'(m_valid));
        check({tag, "/ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, "/busy"}, 32'(busy), 32'(m_active));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all("model");
    endtask

    task automatic gap(int n);
        repeat (n) cycle();
    endtask

    task automatic strobe(logic [DW-1:0] d);
        adc_dt = d;
        adc_en = 1'b1;
        cycle();
        adc_en = 1'b0;
    endtask

    // Reset is asserted and checked between clock edges to exercise the async path.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check("rst_valid", 32'(smp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        #2 rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [NCH-1:0]  mask;
        logic [3:0][1:0] exp_ch;
    } vec_t;

    vec_t vecs [5];
    int   got;

    initial begin
        vecs[0] = '{mask: 4'b1011, exp_ch: {2'd0, 2'd3, 2'd1, 2'd0}};
        vecs[1] = '{mask: 4'b0100, exp_ch: {2'd2, 2'd2, 2'd2, 2'd2}};
        vecs[2] = '{mask: 4'b1000, exp_ch: {2'd3, 2'd3, 2'd3, 2'd3}};
        vecs[3] = '{mask: 4'b0110, exp_ch: {2'd2, 2'd1, 2'd2, 2'd1}};
        vecs[4] = '{mask: 4'b1111, exp_ch: {2'd3, 2'd2, 2'd1, 2'd0}};

        model_reset();
        do_reset();
        gap(2);

        // Round-robin order, one sample per two strobes, data = 100 * channel.
        for (int v = 0; v < 5; v++) begin
            run = 1'b0;
            do_reset();
            ready = 1'b1;
            ch_en = vecs[v].mask;
            run   = 1'b1;
            gap(3);
            got = 0;
            for (int s = 1; s <= 8; s++) begin
                strobe(DW'(100 * int'(mux_sel)));
                check("tbl_valid", 32'(smp_valid), 32'(s % 2 == 0));
                if (smp_valid && got < 4) begin
                    $display("[TB] vec %0d sample ch=%0d dt=%0d", v, smp_ch, smp_dt);
                    check("tbl_ch", 32'(smp_ch), 32'(vecs[v].exp_ch[got]));
                    check("tbl_dt", 32'(smp_dt), 32'(100 * int'(vecs[v].exp_ch[got])));
                    got++;
                end
                gap(3);
            end
            check("tbl_count", 32'(got), 4);
        end

        // Overflow: ready low across three captures, then clear, then same-cycle handshake.
        run = 1'b0;
        do_reset();
        ch_en = 4'b0010; ready = 1'b0; run = 1'b1;
        gap(3);
        strobe(10'd11); gap(2);
        check("ovf_discard_valid", 32'(smp_valid), 0);
        strobe(10'd22); gap(2);
        check("ovf_first_dt", 32'(smp_dt), 22);
        check("ovf_first_ch", 32'(smp_ch), 1);
        check("ovf_first_flag", 32'(ovf), 0);
        strobe(10'd33); gap(2);
        strobe(10'd44); gap(2);
        check("ovf_second_flag", 32'(ovf), 1);
        check("ovf_second_dt", 32'(smp_dt), 22);
        strobe(10'd55); gap(2);
        strobe(10'd66); gap(2);
        check("ovf_third_dt", 32'(smp_dt), 22);
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        check("ovf_clear", 32'(ovf), 0);
        check("ovf_clear_valid", 32'(smp_valid), 1);
        strobe(10'd77); gap(2);
        ready = 1'b1;
        strobe(10'd88);
        check("hs_cap_dt", 32'(smp_dt), 88);
        check("hs_cap_valid", 32'(smp_valid), 1);
        check("hs_cap_ovf", 32'(ovf), 0);
        cycle();
        check("hs_drain_valid", 32'(smp_valid), 0);

        // Run dropped during settle, then restarted at the lowest enabled channel.
        run = 1'b0;
        do_reset();
        ch_en = 4'b1011; ready = 1'b1; run = 1'b1;
        gap(3);
        strobe(10'd1); gap(1);
        strobe(10'd2); gap(2);
        check("stop_busy_before", 32'(busy), 1);
        check("stop_mux_before", 32'(mux_sel), 1);
        run = 1'b0;
        cycle();
        check("stop_busy_after", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            strobe(10'd9); gap(1);
            check("stop_no_sample", 32'(smp_valid), 0);
        end
        run = 1'b1;
        gap(3);
        strobe(10'd5);
        check("restart_discard", 32'(smp_valid), 0);
        gap(1);
        strobe(10'd6);
        check("restart_ch", 32'(smp_ch), 0);
        check("restart_dt", 32'(smp_dt), 6);
        gap(2);

        // Reset while a sample is held and the FSM sits in CAPTURE.
        run = 1'b0;
        do_reset();
        ch_en = 4'b1011; ready = 1'b0; run = 1'b1;
        gap(3);
        strobe(10'd1); gap(1);
        strobe(10'd2); gap(1);
        strobe(10'd3); gap(1);
        check("pre_rst_valid", 32'(smp_valid), 1);
        check("pre_rst_mux", 32'(mux_sel), 1);
        do_reset();
        check("rst_mux", 32'(mux_sel), 0);
        check("rst_dt", 32'(smp_dt), 0);
        ready = 1'b1;
        gap(3);
        strobe(10'd7);
        check("post_rst_discard", 32'(smp_valid), 0);
        gap(1);
        strobe(10'd8);
        check("post_rst_ch", 32'(smp_ch), 0);
        check("post_rst_dt", 32'(smp_dt), 8);

        // Randomized traffic against the model.
        run = 1'b0;
        do_reset();
        ch_en = NCH'($urandom);
        for (int i = 0; i < 3000; i++) begin
            run     = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 31) == 0) ch_en = NCH'($urandom);
            adc_en  = ($urandom_range(0, 3) == 0);
            adc_dt  = DW'($urandom);
            ready   = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        adc_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
